// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ frame generator: host command codes,
// frame FSM states and default framing patterns.
package daq_pkg;
  localparam logic [7:0] CMD_START = 8'hFF;
  localparam logic [7:0] CMD_RESET = 8'hC0;
  localparam logic [7:0] CMD_CLOSE = 8'hC7;

  localparam logic [31:0] DEF_HEAD_WORD = 32'hAAAAAAAA;
  localparam logic [31:0] DEF_TAIL_WORD = 32'hF0F0F0F0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_TAIL,
    ST_HALT
  } state_e;
endpackage

// File: rtl/daq_frame_gen_if.sv
// FIFO / host-stream side of the frame generator: status flags in,
// write strobe and data plus end-of-file out.
interface daq_frame_gen_if #(
  parameter int DATA_W = 32
);
  logic              sink_open;
  logic              sink_afull;
  logic              sink_empty;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              eof;

  modport master (
    input  sink_open, sink_afull, sink_empty,
    output wr_en, wr_data, eof
  );

  modport slave (
    output sink_open, sink_afull, sink_empty,
    input  wr_en, wr_data, eof
  );
endinterface

// File: rtl/daq_pace_div.sv
// Free-running write pacer: tick is high one cycle in every PACE_DIV.
module daq_pace_div #(
  parameter int PACE_DIV = 4
) (
  input  logic bus_clk,
  input  logic rst_n,
  output logic tick
);
  // A one-bit counter is kept for PACE_DIV == 1 so it always reads zero.
  localparam int CW = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CW'(PACE_DIV - 1)) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);
endmodule

// File: rtl/daq_frame_gen.sv
// Frame generator: wraps a counting payload between head and tail words
// and pushes it into the host FIFO, halting on a host-side overflow.
module daq_frame_gen
  import daq_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                FRAME_WORDS = 26,
  parameter logic [DATA_W-1:0] HEAD_WORD   = DATA_W'(DEF_HEAD_WORD),
  parameter logic [DATA_W-1:0] TAIL_WORD   = DATA_W'(DEF_TAIL_WORD),
  parameter int                PACE_DIV    = 4
) (
  input  logic                    bus_clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  input  logic [7:0]              cfg_cmd,
  daq_frame_gen_if.master         sink,
  output logic                    busy,
  output logic                    overflow,
  output logic [31:0]             frame_cnt
);
  localparam int H     = DATA_W / 2;
  localparam int IDX_W = $clog2(FRAME_WORDS);

  // Reset asserts immediately but releases two clocks after rst_n rises.
  logic [1:0] sync_q, sync_d;
  logic       rst_int_n;

  always_comb sync_d = {sync_q[0], 1'b1};

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rst_int_n = sync_q[1];

  logic tick;

  daq_pace_div #(.PACE_DIV(PACE_DIV)) u_pace (
    .bus_clk (bus_clk),
    .rst_n   (rst_int_n),
    .tick    (tick)
  );

  state_e            state_q, state_d;
  logic [H-1:0]      row_q, row_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              close_q, close_d;
  logic              hbn_q, hbn_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       fcnt_q, fcnt_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;

  logic cmd_start, cmd_reset, cmd_close;
  logic active, go, ovf_cond, closing;
  logic [DATA_W-1:0] word;

  always_comb begin
    cmd_start = cfg_valid && (cfg_cmd == CMD_START);
    cmd_reset = cfg_valid && (cfg_cmd == CMD_RESET);
    cmd_close = cfg_valid && (cfg_cmd == CMD_CLOSE);
    active    = (state_q == ST_HEAD) || (state_q == ST_BODY) || (state_q == ST_TAIL);
    go        = active && sink.sink_open && !sink.sink_afull && !ovf_q && tick;
    ovf_cond  = sink.sink_afull && hbn_q && sink.sink_open;
    closing   = close_q || cmd_close;

    unique case (state_q)
      ST_HEAD: word = HEAD_WORD;
      ST_BODY: word = {row_q + H'(1), row_q + H'(2)};
      ST_TAIL: word = TAIL_WORD;
      default: word = '0;
    endcase

    state_d   = state_q;
    row_d     = row_q;
    idx_d     = idx_q;
    close_d   = close_q;
    ovf_d     = ovf_q;
    fcnt_d    = fcnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    hbn_d     = !sink.sink_open ? 1'b0 : (!sink.sink_afull ? 1'b1 : hbn_q);

    if (cmd_reset) begin
      state_d = ST_IDLE;
      row_d   = '0;
      idx_d   = '0;
      close_d = 1'b0;
      ovf_d   = 1'b0;
      fcnt_d  = '0;
    end else if (ovf_cond) begin
      ovf_d   = 1'b1;
      state_d = ST_HALT;
    end else if (state_q == ST_HALT) begin
      if (!sink.sink_open) begin
        state_d = ST_IDLE;
        ovf_d   = 1'b0;
        row_d   = '0;
        idx_d   = '0;
        close_d = 1'b0;
      end
    end else if (active && !sink.sink_open) begin
      // Host dropped the stream mid-frame: abandon it without counting.
      state_d = ST_IDLE;
      row_d   = '0;
      idx_d   = '0;
      close_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (cmd_start) state_d = ST_HEAD;
    end else begin
      close_d = closing;
      if (go) begin
        wr_en_d   = 1'b1;
        wr_data_d = word;
        unique case (state_q)
          ST_HEAD: begin
            row_d   = '0;
            idx_d   = '0;
            state_d = ST_BODY;
          end
          ST_BODY: begin
            row_d = row_q + H'(2);
            if (idx_q == IDX_W'(FRAME_WORDS - 3)) begin
              idx_d   = '0;
              state_d = ST_TAIL;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          ST_TAIL: begin
            fcnt_d = fcnt_q + 32'd1;
            if (closing) begin
              state_d = ST_IDLE;
              close_d = 1'b0;
            end else begin
              state_d = ST_HEAD;
            end
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge bus_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      idx_q     <= '0;
      close_q   <= 1'b0;
      hbn_q     <= 1'b0;
      ovf_q     <= 1'b0;
      fcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      close_q   <= close_d;
      hbn_q     <= hbn_d;
      ovf_q     <= ovf_d;
      fcnt_q    <= fcnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign sink.wr_en   = wr_en_q;
  assign sink.wr_data = wr_data_q;
  assign sink.eof     = sink.sink_empty && ovf_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;
  assign frame_cnt    = fcnt_q;
endmodule
